// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared state and owner encodings for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant with last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_req_if,
    input  logic i_req_dm,
    input  logic i_advance,
    output logic o_gnt_if,
    output logic o_gnt_dm,
    output logic o_any
);

    owner_e r_last;

    // Fetch wins only when alone or when the data port was served last.
    always_comb begin
        o_gnt_if = i_req_if && (!i_req_dm || (r_last == OWN_DM));
        o_gnt_dm = i_req_dm && !o_gnt_if;
        o_any    = o_gnt_if || o_gnt_dm;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_last <= OWN_IF;
        end else if (i_advance) begin
            r_last <= o_gnt_dm ? OWN_DM : OWN_IF;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter in front of a single-port memory,
//               one transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_ready_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_valid_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_ready_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_valid_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);

    state_e r_state;
    state_e w_state_nxt;
    owner_e r_owner;
    owner_e w_owner_nxt;
    logic   r_err;

    logic w_gnt_if;
    logic w_gnt_dm;
    logic w_any;
    logic w_idle;
    logic w_xfer;

    assign w_idle = (r_state == ST_IDLE);
    assign w_xfer = reset_i && w_idle && w_any && mem_ready_i;

    rr_arbiter2 u_rr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .i_req_if  (if_valid_i),
        .i_req_dm  (dm_valid_i),
        .i_advance (w_xfer),
        .o_gnt_if  (w_gnt_if),
        .o_gnt_dm  (w_gnt_dm),
        .o_any     (w_any)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IF;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // A response with nothing outstanding is a protocol violation; latch it.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_err <= 1'b0;
        end else if (w_idle && mem_rvalid_i) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    // Every output is gated by reset_i so nothing leaks while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if_ready_o  = 1'b0;
        dm_ready_o  = 1'b0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rdata_o  = '0;
        mem_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        if (reset_i) begin
            if (w_idle) begin
                mem_valid_o = w_any;
                if (w_gnt_dm) begin
                    mem_we_o    = dm_we_i;
                    mem_addr_o  = dm_addr_i;
                    mem_wdata_o = dm_wdata_i;
                end else if (w_gnt_if) begin
                    mem_addr_o  = if_addr_i;
                end
                if_ready_o = w_gnt_if && mem_ready_i;
                dm_ready_o = w_gnt_dm && mem_ready_i;
                if (w_xfer) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_gnt_dm ? OWN_DM : OWN_IF;
                end
            end else if (mem_rvalid_i) begin
                if (r_owner == OWN_DM) begin
                    dm_rvalid_o = 1'b1;
                    dm_rdata_o  = mem_rdata_i;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
                w_state_nxt = ST_IDLE;
            end
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, memory address width in bits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 if_valid_i  input  1  instruction-fetch read request.
REQ-006 if_addr_i  input  ADDR_WIDTH  fetch address.
REQ-007 if_ready_o  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o  output  1  fetch response valid.
REQ-009 if_rdata_o  output  DATA_WIDTH  fetch read data.
REQ-010 dm_valid_i  input  1  data load/store request.
REQ-011 dm_we_i  input  1  1 = store, 0 = load.
REQ-012 dm_addr_i  input  ADDR_WIDTH  data address.
REQ-013 dm_wdata_i  input  DATA_WIDTH  store data.
REQ-014 dm_ready_o  output  1  data request accepted this cycle.
REQ-015 dm_rvalid_o  output  1  data response valid (load data or store acknowledge).
REQ-016 dm_rdata_o  output  DATA_WIDTH  load data; don't-care on store acknowledge.
REQ-017 mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o  output  1/1/ADDR_WIDTH/DATA_WIDTH  request to the single-port memory.
REQ-018 mem_ready_i  input  1  memory accepts the request this cycle.
REQ-019 mem_rvalid_i, mem_rdata_i  input  1/DATA_WIDTH  memory response, at least 1 cycle after acceptance.
REQ-020 err_o  output  1  sticky protocol error flag.

Function
REQ-021 States: IDLE (no outstanding transaction) and BUSY (one transaction outstanding); at most one transaction outstanding at any time.
REQ-022 In IDLE, the block grants one valid requester combinationally: if only one is valid, that one; if both are valid, the requester not granted most recently (round-robin).
REQ-023 In IDLE, mem_valid_o/mem_we_o/mem_addr_o/mem_wdata_o are driven from the granted requester; mem_we_o is 0 and mem_wdata_o is 0 for a fetch grant.
REQ-024 The granted requester's ready output equals mem_ready_i; the other requester's ready output is 0; both ready outputs are 0 in BUSY.
REQ-025 A transfer occurs when valid and ready are both 1; on transfer, the owner and the last-grant pointer are registered and the state moves to BUSY.
REQ-026 In BUSY, mem_valid_o is 0; when mem_rvalid_i is 1, mem_rdata_i is routed combinationally to the owner's rdata, that owner's rvalid is 1 for exactly that cycle, and the state returns to IDLE on the next edge.
REQ-027 The non-owner's rvalid output is always 0; rdata outputs are 0 whenever their rvalid is 0.
REQ-028 Minimum service is 2 cycles per transaction; a new grant is possible in the cycle after mem_rvalid_i.
REQ-029 A requester that is valid but not ready holds its request; the arbiter does not drop it, and the round-robin guarantees service within 2 transactions.
REQ-030 If mem_rvalid_i is 1 while in IDLE, the response is ignored and err_o is set to 1; err_o stays 1 until reset.
REQ-031 If mem_ready_i is 0, the state, pointer and owner are unchanged.

Reset
REQ-032 While reset_i is 0: state = IDLE, last-grant pointer = fetch (so the data port wins the first tie), owner = fetch, err_o = 0.
REQ-033 While reset_i is 0, all ready/rvalid/mem_valid_o outputs = 0 and data outputs = 0.
REQ-034 A reset asserted in BUSY abandons the transaction; no rvalid is produced for it after reset is released.

Structure
REQ-035 The package mem_arb_pkg holds the state enum (IDLE, BUSY) and the owner enum (OWN_IF, OWN_DM).
REQ-036 A sub-module rr_arbiter2 implements the 2-way round-robin grant logic with its pointer; mem_arbiter holds the FSM and the datapath muxing.

Verification
REQ-037 Fetch only: if_valid_i=1, if_addr_i=3, mem_ready_i=1, memory returns 0xDEADBEEF 1 cycle later -> mem_addr_o=3, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF, dm_rvalid_o=0.
REQ-038 Tie after reset: both valid, dm store addr 7 with data 0x55 -> data granted first (mem_we_o=1, mem_wdata_o=0x55); fetch granted in the next IDLE; the sequence alternates while both stay valid.
REQ-039 Backpressure: both valid, mem_ready_i=0 for 3 cycles -> both ready outputs 0, mem_valid_o=1 held stable with the same address and data; transfer on the first cycle mem_ready_i=1.
REQ-040 Variable latency: load accepted, mem_rvalid_i after 5 cycles -> both ready outputs 0 throughout; dm_rvalid_o pulses exactly once.
REQ-041 Reset in BUSY: reset_i=0 for 1 cycle mid-transaction, then the stale mem_rvalid_i arrives -> no rvalid output, err_o=1.
REQ-042 Spurious response: mem_rvalid_i=1 in IDLE -> no rvalid output, err_o=1 and held until reset_i=0.
